// File: rtl/pre_decode.sv
// pre_decode: registered 1-to-4 priority demultiplexer. Each accepted beat lands in a
// one-entry output buffer chosen by in_sel; per-channel drain counters and an out-of-range counter.
module pre_decode #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [3:0]     in_sel,
    output logic [3:0]     out_valid,
    input  logic [3:0]     out_ready,
    output logic [4*W-1:0] out_data,
    output logic [31:0]    beat_cnt,
    output logic [7:0]     oor_cnt
);

    function automatic logic [1:0] decode_sel(input logic [3:0] sel);
        logic [1:0] t;
        case (sel)
            4'd0:    t = 2'd0;
            4'd1:    t = 2'd1;
            4'd2:    t = 2'd2;
            default: t = 2'd3;
        endcase
        return t;
    endfunction

    logic [1:0]     target_s;
    logic           ready_s;
    logic           accept_s;
    logic           oor_s;
    logic [3:0]     drain_s;
    logic [3:0]     load_s;
    logic [3:0]     out_valid_r;
    logic [4*W-1:0] out_data_r;
    logic [31:0]    beat_cnt_r;
    logic [7:0]     oor_cnt_r;

    // Target decode and handshake; only the target channel can stall the input
    always_comb begin
        target_s = decode_sel(in_sel);
        ready_s  = ~rst & (~out_valid_r[target_s] | out_ready[target_s]);
        accept_s = in_valid & ready_s;
        oor_s    = accept_s & (in_sel >= 4'd4);
        drain_s  = out_valid_r & out_ready;
        load_s   = accept_s ? (4'b0001 << target_s) : 4'b0000;
    end

    // Channel buffers and drain counters; a load wins over a drain so drain+accept refills
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 4'b0000;
            out_data_r  <= {(4*W){1'b0}};
            beat_cnt_r  <= 32'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load_s[k]) begin
                    out_valid_r[k]       <= 1'b1;
                    out_data_r[k*W +: W] <= in_data;
                end else if (drain_s[k]) begin
                    out_valid_r[k] <= 1'b0;
                end else begin
                    out_valid_r[k] <= out_valid_r[k];
                end
                if (drain_s[k]) begin
                    beat_cnt_r[k*8 +: 8] <= beat_cnt_r[k*8 +: 8] + 8'd1;
                end else begin
                    beat_cnt_r[k*8 +: 8] <= beat_cnt_r[k*8 +: 8];
                end
            end
        end
    end

    // Saturating count of accepted beats whose select was above 3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_cnt_r <= 8'd0;
        end else if (oor_s && (oor_cnt_r != 8'hFF)) begin
            oor_cnt_r <= oor_cnt_r + 8'd1;
        end else begin
            oor_cnt_r <= oor_cnt_r;
        end
    end

    assign in_ready  = ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign beat_cnt  = beat_cnt_r;
    assign oor_cnt   = oor_cnt_r;

endmodule

// File: tb/tb_pre_decode.sv
// Directed and randomized bench for pre_decode; expected values are hand-computed
// or come from a small per-channel model inside the bench.
module tb_pre_decode;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = 4'h0;
    logic [3:0]     in_sel = 4'h0;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready = 4'h0;
    logic [4*W-1:0] out_data;
    logic [31:0]    beat_cnt;
    logic [7:0]     oor_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pre_decode #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_cnt(beat_cnt), .oor_cnt(oor_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; in_sel = 4'h0; in_data = 4'h0; out_ready = 4'h0;
        step; step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_sel = 4'h0; in_data = 4'h5; out_ready = 4'hF;
        step;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 4'h0) begin n_err++; $display("FAIL reset_out_valid: got %h want 0", out_valid); end
        n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (beat_cnt !== 32'h0) begin n_err++; $display("FAIL reset_beat_cnt: got %h want 0", beat_cnt); end
        n_cmp++; if (oor_cnt !== 8'h0) begin n_err++; $display("FAIL reset_oor_cnt: got %h want 0", oor_cnt); end
        in_valid = 1'b0;
    endtask

    task automatic test_routing;
        logic [3:0] dv [4];
        dv[0] = 4'hA; dv[1] = 4'hB; dv[2] = 4'hC; dv[3] = 4'hD;
        do_reset;
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_sel = k[3:0]; in_data = dv[k];
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL route_ready ch%0d: got %b want 1", k, in_ready); end
            step;
            n_cmp++; if (out_valid[k] !== 1'b1) begin n_err++; $display("FAIL route_valid ch%0d: got %b want 1", k, out_valid[k]); end
            n_cmp++; if (out_data[k*W +: W] !== dv[k]) begin n_err++; $display("FAIL route_data ch%0d: got %h want %h", k, out_data[k*W +: W], dv[k]); end
        end
        in_valid = 1'b0;
        step;
        n_cmp++; if (out_data !== 16'hDCBA) begin n_err++; $display("FAIL route_all_data: got %h want dcba", out_data); end
        n_cmp++; if (beat_cnt !== 32'h01010101) begin n_err++; $display("FAIL route_beat_cnt: got %h want 01010101", beat_cnt); end
        n_cmp++; if (oor_cnt !== 8'h0) begin n_err++; $display("FAIL route_oor_cnt: got %h want 0", oor_cnt); end
        n_cmp++; if (out_valid !== 4'h0) begin n_err++; $display("FAIL route_drained: got %h want 0", out_valid); end
    endtask

    task automatic test_oor;
        do_reset;
        out_ready = 4'hF;
        in_valid = 1'b1; in_sel = 4'hF; in_data = 4'hE;
        step;
        n_cmp++; if (out_data[15:12] !== 4'hE || out_valid !== 4'h8) begin n_err++; $display("FAIL oor_first: got v=%h d=%h want v=8 d=e", out_valid, out_data[15:12]); end
        in_sel = 4'h8; in_data = 4'h5;
        step;
        in_valid = 1'b0;
        n_cmp++; if (out_data[15:12] !== 4'h5 || out_valid !== 4'h8) begin n_err++; $display("FAIL oor_second: got v=%h d=%h want v=8 d=5", out_valid, out_data[15:12]); end
        n_cmp++; if (oor_cnt !== 8'd2) begin n_err++; $display("FAIL oor_cnt: got %0d want 2", oor_cnt); end
        n_cmp++; if (out_data[11:0] !== 12'h000) begin n_err++; $display("FAIL oor_others: got %h want 000", out_data[11:0]); end
        in_valid = 1'b1; in_sel = 4'h3; in_data = 4'h6;
        step;
        in_valid = 1'b0;
        n_cmp++; if (oor_cnt !== 8'd2 || out_data[15:12] !== 4'h6) begin n_err++; $display("FAIL oor_sel3: got cnt=%0d d=%h want cnt=2 d=6", oor_cnt, out_data[15:12]); end
    endtask

    task automatic test_backpressure;
        do_reset;
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 4'h1; in_data = 4'h1;
        step;
        n_cmp++; if (out_valid !== 4'h2 || out_data[7:4] !== 4'h1) begin n_err++; $display("FAIL bp_first: got v=%h d=%h want v=2 d=1", out_valid, out_data[7:4]); end
        in_data = 4'h2;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hol_ready: got %b want 0", in_ready); end
        step;
        n_cmp++; if (out_valid !== 4'h2 || out_data[7:4] !== 4'h1) begin n_err++; $display("FAIL bp_hold: got v=%h d=%h want v=2 d=1", out_valid, out_data[7:4]); end
        in_sel = 4'h2;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_other_ready: got %b want 1", in_ready); end
        step;
        n_cmp++; if (out_valid !== 4'h6 || out_data[11:8] !== 4'h2 || out_data[7:4] !== 4'h1) begin n_err++; $display("FAIL bp_other_accept: got v=%h d=%h want v=6 d=210", out_valid, out_data[11:0]); end
        in_sel = 4'h1; in_data = 4'h2; out_ready = 4'h2;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        step;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'h6 || out_data[7:4] !== 4'h2) begin n_err++; $display("FAIL bp_swap: got v=%h d=%h want v=6 d=2", out_valid, out_data[7:4]); end
        n_cmp++; if (beat_cnt !== 32'h00000100) begin n_err++; $display("FAIL bp_beat_cnt: got %h want 00000100", beat_cnt); end
        step;
        n_cmp++; if (out_valid !== 4'h4 || beat_cnt !== 32'h00000200) begin n_err++; $display("FAIL bp_final: got v=%h cnt=%h want v=4 cnt=00000200", out_valid, beat_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] d;
        do_reset;
        out_ready = 4'h1;
        for (int i = 0; i < 20; i++) begin
            d = 4'(i * 3 + 1);
            in_valid = 1'b1; in_sel = 4'h0; in_data = d;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready beat %0d: got %b want 1", i, in_ready); end
            step;
            n_cmp++; if (out_valid[0] !== 1'b1 || out_data[3:0] !== d) begin n_err++; $display("FAIL b2b_data beat %0d: got v=%b d=%h want v=1 d=%h", i, out_valid[0], out_data[3:0], d); end
        end
        in_valid = 1'b0;
        step;
        n_cmp++; if (beat_cnt[7:0] !== 8'd20 || out_valid !== 4'h0) begin n_err++; $display("FAIL b2b_count: got cnt=%0d v=%h want cnt=20 v=0", beat_cnt[7:0], out_valid); end
        out_ready = 4'h3;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sel = {3'b000, i[0]}; in_data = 4'(i + 8);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL alt_ready beat %0d: got %b want 1", i, in_ready); end
            step;
        end
        in_valid = 1'b0;
        step;
        n_cmp++; if (beat_cnt[15:0] !== 16'h0418) begin n_err++; $display("FAIL alt_count: got %h want 0418", beat_cnt[15:0]); end
    endtask

    task automatic test_wrap_saturate;
        do_reset;
        out_ready = 4'hF;
        in_valid = 1'b1; in_sel = 4'h2;
        for (int i = 0; i < 256; i++) begin
            in_data = 4'(i);
            step;
        end
        n_cmp++; if (beat_cnt[23:16] !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d want 255", beat_cnt[23:16]); end
        in_valid = 1'b0;
        step;
        n_cmp++; if (beat_cnt[23:16] !== 8'd0) begin n_err++; $display("FAIL wrap_0: got %0d want 0", beat_cnt[23:16]); end
        in_valid = 1'b1; in_sel = 4'h7;
        for (int i = 0; i < 300; i++) begin
            step;
            if (i == 253) begin
                n_cmp++; if (oor_cnt !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d want 254", oor_cnt); end
            end
            if (i == 254) begin
                n_cmp++; if (oor_cnt !== 8'd255) begin n_err++; $display("FAIL sat_255: got %0d want 255", oor_cnt); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (oor_cnt !== 8'd255) begin n_err++; $display("FAIL sat_hold: got %0d want 255", oor_cnt); end
        n_cmp++; if (beat_cnt[31:24] !== 8'd43) begin n_err++; $display("FAIL ch3_wrap: got %0d want 43", beat_cnt[31:24]); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        out_ready = 4'hF;
        in_valid = 1'b1; in_sel = 4'h1; in_data = 4'h7;
        step;
        in_valid = 1'b0;
        step;
        out_ready = 4'h0;
        in_valid = 1'b1;
        in_sel = 4'h0; in_data = 4'h1; step;
        in_sel = 4'h1; in_data = 4'h2; step;
        in_sel = 4'h2; in_data = 4'h3; step;
        in_sel = 4'hC; in_data = 4'h4; step;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'hF || out_data !== 16'h4321 || beat_cnt !== 32'h100 || oor_cnt !== 8'd1) begin
            n_err++; $display("FAIL mid_fill: got v=%h d=%h cnt=%h oor=%0d want v=f d=4321 cnt=100 oor=1", out_valid, out_data, beat_cnt, oor_cnt);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 4'h0 || out_data !== 16'h0) begin n_err++; $display("FAIL mid_rst_buf: got v=%h d=%h want 0", out_valid, out_data); end
        n_cmp++; if (beat_cnt !== 32'h0 || oor_cnt !== 8'h0) begin n_err++; $display("FAIL mid_rst_cnt: got cnt=%h oor=%h want 0", beat_cnt, oor_cnt); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
        #1;
        rst = 1'b0;
        out_ready = 4'hF; in_valid = 1'b1; in_sel = 4'h2; in_data = 4'h9;
        step;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'h4 || out_data[11:8] !== 4'h9) begin n_err++; $display("FAIL mid_after: got v=%h d=%h want v=4 d=9", out_valid, out_data[11:8]); end
    endtask

    task automatic test_random;
        logic [3:0]     ev;
        logic [4*W-1:0] ed;
        logic [31:0]    eb;
        logic [7:0]     eo;
        logic           er;
        logic [1:0]     t;
        do_reset;
        ev = 4'h0; ed = 16'h0; eb = 32'h0; eo = 8'h0; er = 1'b1;
        for (int c = 0; c < 400; c++) begin
            n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL rnd_valid cyc %0d: got %h want %h", c, out_valid, ev); end
            n_cmp++; if (out_data !== ed) begin n_err++; $display("FAIL rnd_data cyc %0d: got %h want %h", c, out_data, ed); end
            n_cmp++; if (beat_cnt !== eb) begin n_err++; $display("FAIL rnd_beat cyc %0d: got %h want %h", c, beat_cnt, eb); end
            n_cmp++; if (oor_cnt !== eo) begin n_err++; $display("FAIL rnd_oor cyc %0d: got %h want %h", c, oor_cnt, eo); end
            if (!(in_valid && !er)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_sel   = 4'($urandom_range(0, 5));
                in_data  = 4'($urandom_range(0, 15));
            end
            out_ready = 4'($urandom_range(0, 15));
            #1;
            t  = (in_sel <= 4'd2) ? in_sel[1:0] : 2'd3;
            er = !ev[t] || out_ready[t];
            n_cmp++; if (in_ready !== er) begin n_err++; $display("FAIL rnd_ready cyc %0d: got %b want %b", c, in_ready, er); end
            for (int k = 0; k < 4; k++) begin
                if (ev[k] && out_ready[k]) eb[k*8 +: 8] = eb[k*8 +: 8] + 8'd1;
                if (in_valid && er && (t == k[1:0])) begin
                    ev[k] = 1'b1;
                    ed[k*W +: W] = in_data;
                end else if (ev[k] && out_ready[k]) begin
                    ev[k] = 1'b0;
                end
            end
            if (in_valid && er && (in_sel >= 4'd4) && (eo != 8'hFF)) eo = eo + 8'd1;
            step;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_routing;
        test_oor;
        test_backpressure;
        test_back_to_back;
        test_wrap_saturate;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pre_decode.md
# pre_decode

Registered 1-to-4 priority demultiplexer/dispatcher. It is the inverse of the 4-to-1 `pre_encode` priority mux. One input stream carries a 4-bit select. Each accepted beat is steered into one of four output channels using the same decode rule as the mux: 0→ch0, 1→ch1, 2→ch2, any other value→ch3. Each channel has a one-entry output register with valid/ready handshake and a per-channel delivered-beat counter. The block sits on the producer side of the mux/demux pair for bus-fanout experiments.

## Interface
- `W`, default 4: data width per beat.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the input beat this cycle.
- `in_data`  in  W  input payload.
- `in_sel`  in  4  channel select; decoded as 0/1/2 → ch0/ch1/ch2, else → ch3.
- `out_valid`  out  4  bit k: channel k holds a beat.
- `out_ready`  in  4  bit k: consumer of channel k takes the beat.
- `out_data`  out  4*W  channel k payload at bits [k*W +: W].
- `beat_cnt`  out  32  channel k delivered-beat count at bits [k*8 +: 8].
- `oor_cnt`  out  8  count of accepted beats whose `in_sel` > 3.

## Operation
- **Decode.** Target channel `t` = `in_sel` when `in_sel` ≤ 2, else 3.
  - `in_sel` = 3 and `in_sel` = 4..15 all route to ch3.
  - Only `in_sel` ≥ 4 increments `oor_cnt`.
- **Channel register.** Each channel is a one-entry buffer with state EMPTY (out_valid=0) or FULL (out_valid=1).
  - EMPTY→FULL on accept into this channel.
  - FULL→EMPTY on drain, i.e. `out_valid[k]` & `out_ready[k]` with no accept into k.
  - FULL→FULL with new data on simultaneous drain and accept into k.
- **in_ready.** Combinational: `!rst & (!out_valid[t] | out_ready[t])`.
  - Depends only on the target channel.
  - A full, stalled target channel blocks the input (head-of-line blocking).
  - Other channels keep draining independently during such a stall.
- **Accept** = `in_valid & in_ready`. On accept, `out_data[t]` ← `in_data` and `out_valid[t]` ← 1.
- **Data stability.** `out_data[k]` holds its value while `out_valid[k]`=1 and `out_ready[k]`=0.
  - Non-target channels are never modified by an accept.
- **beat_cnt[k].** Increments on each drain of channel k (`out_valid[k]` & `out_ready[k]`). 8-bit, wraps 255→0.
- **oor_cnt.** Increments on accept with `in_sel` ≥ 4. 8-bit, saturates at 255.
- **Reset values.** All of `out_valid`, `out_data`, `beat_cnt` and `oor_cnt` are 0. `in_ready` is 0 while `rst` is high.
- **Reset mid-operation.** Asserting `rst` discards all buffered beats immediately (asynchronous). No partial beats survive. Counters clear.

## Timing
- Latency: a beat accepted at edge n is visible on `out_valid[t]`/`out_data[t]` after edge n (i.e. in cycle n+1).
- Throughput: 1 beat/cycle sustained when the target consumer holds `out_ready` high.
  - Consecutive beats to the same channel pass back-to-back.
  - Beats alternating between channels also pass back-to-back.
- `in_ready` is combinational from `in_sel`, `out_valid`, `out_ready` and `rst`. There is no combinational path from `in_valid` to `in_ready`.
- The producer must hold `in_data`/`in_sel` stable while `in_valid`=1 and `in_ready`=0.
- Counter updates appear the cycle after the qualifying edge.
- Reset release: first accept is possible on the first rising edge after `rst` falls.

## Test plan
- **Directed routing.** `out_ready`=4'hF. Send data A,B,C,D with `in_sel`=0,1,2,3 on consecutive cycles.
  - Expect `out_data` ch0=A, ch1=B, ch2=C, ch3=D, each one cycle after its accept.
  - Expect `beat_cnt`=0x01010101 and `oor_cnt`=0.
- **Out-of-range select.** Send E with `in_sel`=4'hF, then 5 with `in_sel`=4'h8.
  - Expect both beats on ch3 and `oor_cnt`=2.
  - Expect ch0..ch2 untouched.
- **Backpressure and HOL.** `out_ready`=0. Send 1 to ch1 (accepted). Present 2 to ch1: expect `in_ready`=0 and ch1 holding 1 stable.
  - Change the offered beat to ch2: expect it accepted.
  - Raise `out_ready[1]`: expect 1 to drain and 2 to be accepted in the same cycle.
- **Simultaneous drain and fill.** Stream 20 beats to ch0 with `out_ready[0]`=1.
  - Expect no bubbles, output order preserved, and `beat_cnt[ch0]`=20.
- **Wrap and saturate.** Drain 256 beats through ch2: expect `beat_cnt[ch2]`=0.
  - Send 300 beats with `in_sel`=7: expect `oor_cnt`=255.
- **Reset mid-operation.** With all 4 channels FULL, pulse `rst` asynchronously mid-cycle.
  - Expect `out_valid`=0, `out_data`=0, counters 0 and `in_ready`=0 immediately.
  - After release, expect normal routing.
- **Randomized check.** Random `in_valid`, `out_ready`, `in_sel` and `in_data` are compared against a four-queue scoreboard model. Expect zero mismatches.
